// File: rtl/iig_18x18_if.sv
// ---------------------------------------------------------------------------
// iig_18x18_if
// Pixel-in / integral-out bundle for the integral-image generator.
//   iStart  : one-cycle frame start (abort when a frame is in progress)
//   iValid  : iPixel is valid this cycle
//   iPixel  : unsigned PW-bit pixel
//   oWrreq  : oData is valid (write request to the integral-image buffer)
//   oData   : DW-bit integral value
//   oFull   : one-cycle pulse once a whole frame has been written
//   oBusy   : generator is inside a frame (RUN or DONE)
// master = pixel source / buffer side, slave = the generator.
// ---------------------------------------------------------------------------
interface iig_18x18_if #(
  parameter int PW = 8,
  parameter int DW = 21
) ();
  logic          iStart;
  logic          iValid;
  logic [PW-1:0] iPixel;
  logic          oWrreq;
  logic [DW-1:0] oData;
  logic          oFull;
  logic          oBusy;

  modport master (
    output iStart, iValid, iPixel,
    input  oWrreq, oData, oFull, oBusy
  );

  modport slave (
    input  iStart, iValid, iPixel,
    output oWrreq, oData, oFull, oBusy
  );
endinterface

// File: rtl/iig_18x18.sv
// ---------------------------------------------------------------------------
// iig_18x18
// Integral-image generator. Takes a ROWS x COLS window of pixels in row-major
// order and emits ii(r,c) = sum of p(i,j) for i<=r, j<=c, one value per
// accepted pixel, one cycle after acceptance. After the last value of a frame
// it pulses oFull for one cycle.
// Ports:
//   iClk    : clock, rising edge
//   iReset  : asynchronous, active-high reset
//   bus     : iig_18x18_if.slave (iStart/iValid/iPixel in,
//             oWrreq/oData/oFull/oBusy out, all outputs registered)
// ---------------------------------------------------------------------------
module iig_18x18 #(
  parameter int COLS = 18,
  parameter int ROWS = 18,
  parameter int PW   = 8,
  parameter int DW   = 21
) (
  input  logic        iClk,
  input  logic        iReset,
  iig_18x18_if.slave  bus
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

  // Integral values must hold the sum of a full frame of maximum pixels.
  if (DW < PW + $clog2(ROWS * COLS)) begin : g_dw_check
    $error("iig_18x18: DW too small for ROWS*COLS pixels of PW bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [RW-1:0] r_r;
  logic [CW-1:0] c_r;
  logic [DW-1:0] s_r;
  logic [DW-1:0] line_r [COLS];

  logic          wrreq_r;
  logic [DW-1:0] data_r;
  logic          full_r;
  logic          busy_r;

  logic          accept_s;
  logic [RW-1:0] base_r_s;
  logic [CW-1:0] base_c_s;
  logic [DW-1:0] row_sum_s;
  logic [DW-1:0] line_val_s;
  logic [DW-1:0] ii_s;
  logic          last_s;
  logic [RW-1:0] next_r_s;
  logic [CW-1:0] next_c_s;

  // Accept decision, coordinates of the pixel being accepted and its integral.
  always_comb begin
    accept_s   = 1'b0;
    base_r_s   = {RW{1'b0}};
    base_c_s   = {CW{1'b0}};
    row_sum_s  = {DW{1'b0}};
    line_val_s = {DW{1'b0}};
    ii_s       = {DW{1'b0}};
    last_s     = 1'b0;
    next_r_s   = {RW{1'b0}};
    next_c_s   = {CW{1'b0}};

    // Only RUN accepts; a pixel alongside iStart belongs to the new frame.
    if (state_r == ST_RUN && bus.iValid) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end

    if (bus.iStart) begin
      base_r_s = {RW{1'b0}};
      base_c_s = {CW{1'b0}};
    end else begin
      base_r_s = r_r;
      base_c_s = c_r;
    end

    // Row sum restarts at column 0 instead of being cleared separately.
    if (base_c_s == {CW{1'b0}}) begin
      row_sum_s = DW'(bus.iPixel);
    end else begin
      row_sum_s = s_r + DW'(bus.iPixel);
    end

    // Row 0 masks whatever the line buffer holds from an earlier frame.
    if (base_r_s == {RW{1'b0}}) begin
      line_val_s = {DW{1'b0}};
    end else begin
      line_val_s = line_r[base_c_s];
    end

    ii_s   = line_val_s + row_sum_s;
    last_s = (base_r_s == R_LAST) && (base_c_s == C_LAST);

    if (base_c_s == C_LAST) begin
      next_c_s = {CW{1'b0}};
      if (last_s) begin
        next_r_s = {RW{1'b0}};
      end else begin
        next_r_s = base_r_s + RW'(1'b1);
      end
    end else begin
      next_c_s = base_c_s + CW'(1'b1);
      next_r_s = base_r_s;
    end
  end

  // Line buffer: column c keeps ii(r-1,c) until overwritten by ii(r,c).
  always_ff @(posedge iClk) begin
    if (accept_s) begin
      line_r[base_c_s] <= ii_s;
    end
  end

  // Frame FSM, coordinate/row-sum state and registered outputs.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_r <= ST_IDLE;
      r_r     <= {RW{1'b0}};
      c_r     <= {CW{1'b0}};
      s_r     <= {DW{1'b0}};
      wrreq_r <= 1'b0;
      data_r  <= {DW{1'b0}};
      full_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      wrreq_r <= 1'b0;
      full_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.iStart) begin
            state_r <= ST_RUN;
            r_r     <= {RW{1'b0}};
            c_r     <= {CW{1'b0}};
            s_r     <= {DW{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end

        ST_RUN: begin
          busy_r <= 1'b1;
          if (accept_s) begin
            wrreq_r <= 1'b1;
            data_r  <= ii_s;
            s_r     <= row_sum_s;
            r_r     <= next_r_s;
            c_r     <= next_c_s;
            if (last_s) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_RUN;
            end
          end else if (bus.iStart) begin
            // Abort without a pixel: restart the frame, no oFull.
            state_r <= ST_RUN;
            r_r     <= {RW{1'b0}};
            c_r     <= {CW{1'b0}};
            s_r     <= {DW{1'b0}};
          end else begin
            state_r <= ST_RUN;
          end
        end

        ST_DONE: begin
          full_r <= 1'b1;
          r_r    <= {RW{1'b0}};
          c_r    <= {CW{1'b0}};
          s_r    <= {DW{1'b0}};
          if (bus.iStart) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oWrreq = wrreq_r;
  assign bus.oData  = data_r;
  assign bus.oFull  = full_r;
  assign bus.oBusy  = busy_r;

endmodule

// File: tb/tb_iig_18x18.sv
module tb_iig_18x18;

  localparam int NPIX = 324;

  logic iClk = 1'b0;
  logic iReset;
  always #5 iClk = ~iClk;

  iig_18x18_if #(.PW(8), .DW(21)) bus ();

  iig_18x18 #(.COLS(18), .ROWS(18), .PW(8), .DW(21)) dut (
    .iClk  (iClk),
    .iReset(iReset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Behavioural model: frame phase, pixels of the current frame, expectations.
  int mode;                 // 0 idle, 1 running, 2 frame just completed
  int k;                    // pixels accepted in the current frame
  int unsigned pix [NPIX];
  logic        exp_wrreq, exp_full, exp_busy;
  logic [20:0] exp_data;

  int unsigned wr_log [$];
  int full_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Direct double sum over the stored frame pixels.
  function automatic int unsigned ii_model(input int idx);
    int unsigned sum = 0;
    int rr = idx / 18;
    int cc = idx % 18;
    for (int i = 0; i <= rr; i++)
      for (int j = 0; j <= cc; j++)
        sum += pix[i*18 + j];
    return sum;
  endfunction

  function automatic int unsigned qget(input int i);
    if (i >= 0 && i < wr_log.size()) return wr_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_step(input logic st, input logic v, input logic [7:0] p);
    exp_wrreq = 1'b0;
    exp_full  = 1'b0;
    case (mode)
      0: if (st) begin mode = 1; k = 0; end
      1: begin
        if (st) k = 0;
        if (v) begin
          pix[k]    = p;
          exp_data  = 21'(ii_model(k));
          exp_wrreq = 1'b1;
          k++;
          if (k == NPIX) mode = 2;
        end
      end
      default: begin
        exp_full = 1'b1;
        mode = st ? 1 : 0;
        k = 0;
      end
    endcase
    exp_busy = (mode != 0);
  endtask

  task automatic cycle(input logic st, input logic v, input logic [7:0] p);
    bus.iStart = st;
    bus.iValid = v;
    bus.iPixel = p;
    @(posedge iClk);
    model_step(st, v, p);
    #1;
  endtask

  function automatic logic [7:0] pix_of(input int kind, input int idx);
    if (kind == 0) return 8'd1;
    if (kind == 1) return 8'd255;
    return 8'(idx);
  endfunction

  task automatic frame(input int kind, input int gap);
    int idx = 0;
    while (idx < NPIX) begin
      if (int'($urandom_range(99)) < gap) cycle(1'b0, 1'b0, 8'h00);
      else begin
        cycle(1'b0, 1'b1, pix_of(kind, idx));
        idx++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_log();
    wr_log.delete();
    full_cnt = 0;
  endtask

  // Per-cycle comparison against the model, plus a log of DUT writes.
  always @(negedge iClk) begin
    if (chk_en) begin
      check("wrreq", 32'(bus.oWrreq), 32'(exp_wrreq));
      check("full",  32'(bus.oFull),  32'(exp_full));
      check("busy",  32'(bus.oBusy),  32'(exp_busy));
      if (exp_wrreq) check("data", 32'(bus.oData), 32'(exp_data));
      if (bus.oWrreq === 1'b1) wr_log.push_back(32'(bus.oData));
      if (bus.oFull === 1'b1) full_cnt++;
    end
  end

  initial begin
    mode = 0; k = 0;
    exp_wrreq = 1'b0; exp_full = 1'b0; exp_busy = 1'b0; exp_data = 21'd0;
    full_cnt = 0;
    bus.iStart = 1'b0; bus.iValid = 1'b0; bus.iPixel = 8'h00;
    iReset = 1'b1;

    // Reset values.
    @(negedge iClk);
    check("rst_wrreq", 32'(bus.oWrreq), 32'd0);
    check("rst_data",  32'(bus.oData),  32'd0);
    check("rst_full",  32'(bus.oFull),  32'd0);
    check("rst_busy",  32'(bus.oBusy),  32'd0);
    chk_en = 1'b1;
    @(posedge iClk); #1;
    iReset = 1'b0;
    idle(2);

    // Pixels in IDLE are ignored.
    cycle(1'b0, 1'b1, 8'd7);
    idle(1);

    // All-ones, continuous.
    clear_log();
    cycle(1'b1, 1'b0, 8'h00);
    frame(0, 0);
    idle(4);
    check("ones_count", 32'(wr_log.size()), 32'd324);
    check("ones_w1",    qget(0),   32'd1);
    check("ones_w18",   qget(17),  32'd18);
    check("ones_w19",   qget(18),  32'd2);
    check("ones_w324",  qget(323), 32'd324);
    check("ones_full",  32'(full_cnt), 32'd1);

    // All-255 with ~50% gaps.
    clear_log();
    cycle(1'b1, 1'b0, 8'h00);
    frame(1, 50);
    idle(4);
    check("max_count", 32'(wr_log.size()), 32'd324);
    check("max_last",  qget(323), 32'd82620);
    check("max_full",  32'(full_cnt), 32'd1);

    // Ramp right after the 255 frame (stale line buffer must be masked).
    clear_log();
    cycle(1'b1, 1'b0, 8'h00);
    frame(2, 0);
    idle(4);
    check("ramp_count", 32'(wr_log.size()), 32'd324);
    check("ramp_w2",    qget(1), 32'd1);
    check("ramp_full",  32'(full_cnt), 32'd1);

    // Abort after 100 pixels, then a full all-ones frame.
    clear_log();
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 8'd1);
    cycle(1'b1, 1'b0, 8'h00);
    frame(0, 0);
    idle(4);
    check("abort_count", 32'(wr_log.size()), 32'd424);
    check("abort_first", qget(100), 32'd1);
    check("abort_last",  qget(423), 32'd324);
    check("abort_full",  32'(full_cnt), 32'd1);

    // Restart carrying pixel (0,0) in the same cycle as iStart.
    clear_log();
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 8'(i + 3));
    cycle(1'b1, 1'b1, 8'd9);
    for (int i = 1; i < NPIX; i++) cycle(1'b0, 1'b1, 8'($urandom_range(255)));
    idle(4);
    check("rs_first", qget(30), 32'd9);
    check("rs_full",  32'(full_cnt), 32'd1);

    // 330 valid pixels: extras dropped.
    clear_log();
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 330; i++) cycle(1'b0, 1'b1, 8'd1);
    idle(4);
    check("extra_count", 32'(wr_log.size()), 32'd324);
    check("extra_full",  32'(full_cnt), 32'd1);

    // Async reset between edges at pixel 200.
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 200; i++) cycle(1'b0, 1'b1, 8'(1 + $urandom_range(200)));
    bus.iValid = 1'b0;
    #2;
    iReset = 1'b1;
    #1;
    check("arst_wrreq", 32'(bus.oWrreq), 32'd0);
    check("arst_data",  32'(bus.oData),  32'd0);
    check("arst_full",  32'(bus.oFull),  32'd0);
    check("arst_busy",  32'(bus.oBusy),  32'd0);
    mode = 0; k = 0;
    exp_wrreq = 1'b0; exp_full = 1'b0; exp_busy = 1'b0; exp_data = 21'd0;
    @(posedge iClk); #1;
    iReset = 1'b0;
    clear_log();
    cycle(1'b1, 1'b0, 8'h00);
    frame(0, 20);
    idle(4);
    check("post_count", 32'(wr_log.size()), 32'd324);
    check("post_first", qget(0),   32'd1);
    check("post_last",  qget(323), 32'd324);
    check("post_full",  32'(full_cnt), 32'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
